// File: rtl/fixed_addsub_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fixed_addsub_arbiter
// Brief    : Two-requester round-robin front end for one shared Q16.16
//            add/subtract unit. It has a registered result slot with a
//            requester ID, a signed-overflow flag, optional saturation and
//            a saturating count of overflows.
// Revision : 1.0 - initial release
// ============================================================================
module fixed_addsub_arbiter #(
    parameter bit SAT = 1'b0
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        req0_valid_i,
    output logic        req0_ready_o,
    input  logic [31:0] req0_a_i,
    input  logic [31:0] req0_b_i,
    input  logic        req0_sub_i,

    input  logic        req1_valid_i,
    output logic        req1_ready_o,
    input  logic [31:0] req1_a_i,
    input  logic [31:0] req1_b_i,
    input  logic        req1_sub_i,

    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic        rsp_id_o,
    output logic [31:0] rsp_result_o,
    output logic        rsp_overflow_o,
    output logic [7:0]  ovf_count_o
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t      state_q;
    logic        rr_q;          // 0: req0 wins a tie, 1: req1 wins a tie
    logic        rsp_id_q;
    logic [31:0] rsp_result_q;
    logic        rsp_overflow_q;
    logic [7:0]  ovf_count_q;

    logic        w_slot_free;
    logic        w_gnt0;
    logic        w_gnt1;
    logic        w_accept;
    logic [31:0] w_a;
    logic [31:0] w_b;
    logic        w_sub;
    logic [31:0] w_b_eff;
    logic [31:0] w_raw;
    logic        w_ovf;
    logic [31:0] w_result_d;

    // Grant, handshake and shared-datapath arithmetic for the chosen requester
    always_comb begin
        // A result being drained this cycle frees the slot for a new one
        w_slot_free  = (state_q == IDLE) || rsp_ready_i;
        w_gnt0       = req0_valid_i && (!req1_valid_i || !rr_q);
        w_gnt1       = req1_valid_i && (!req0_valid_i ||  rr_q);
        req0_ready_o = w_gnt0 && w_slot_free && !rst;
        req1_ready_o = w_gnt1 && w_slot_free && !rst;
        w_accept     = req0_ready_o || req1_ready_o;

        w_a   = w_gnt1 ? req1_a_i   : req0_a_i;
        w_b   = w_gnt1 ? req1_b_i   : req0_b_i;
        w_sub = w_gnt1 ? req1_sub_i : req0_sub_i;

        // Two's-complement negate; -0x80000000 wraps back to 0x80000000
        w_b_eff = w_sub ? (32'd0 - w_b) : w_b;
        w_raw   = w_a + w_b_eff;
        w_ovf   = (w_a[31] == w_b_eff[31]) && (w_raw[31] != w_a[31]);

        w_result_d = w_raw;
        if (SAT && w_ovf) begin
            w_result_d = w_a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end
    end

    // Result slot FSM, round-robin pointer and overflow counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            rr_q           <= 1'b0;
            rsp_id_q       <= 1'b0;
            rsp_result_q   <= 32'd0;
            rsp_overflow_q <= 1'b0;
            ovf_count_q    <= 8'd0;
        end else begin
            if (w_accept) begin
                state_q        <= HOLD;
                rsp_id_q       <= w_gnt1;
                rsp_result_q   <= w_result_d;
                rsp_overflow_q <= w_ovf;
                // Favour the other requester on the next tie
                rr_q           <= !w_gnt1;
                if (w_ovf && (ovf_count_q != 8'hFF)) begin
                    ovf_count_q <= ovf_count_q + 8'd1;
                end
            end else if ((state_q == HOLD) && rsp_ready_i) begin
                state_q <= IDLE;
            end
        end
    end

    assign rsp_valid_o    = (state_q == HOLD);
    assign rsp_id_o       = rsp_id_q;
    assign rsp_result_o   = rsp_result_q;
    assign rsp_overflow_o = rsp_overflow_q;
    assign ovf_count_o    = ovf_count_q;

endmodule
`default_nettype wire
